// File: rtl/idct_product_accumulator.sv
// Sums TERMS signed products per IDCT coefficient, then rounds, shifts and saturates
// the sum and hands it out on a valid/ready port indexed within the 8x8 block.
module idct_product_accumulator #(
    parameter int P_BITWIDTH   = 32,
    parameter int ACC_BITWIDTH = 36,
    parameter int OUT_BITWIDTH = 16,
    parameter int TERMS        = 8,
    parameter int SHIFT_ROW    = 11,
    parameter int SHIFT_COL    = 14
) (
    input  logic                           clk,
    input  logic                           rstP,
    input  logic signed [P_BITWIDTH-1:0]   p,
    input  logic                           p_valid,
    output logic                           p_ready,
    input  logic                           pass,
    input  logic                           flush,
    output logic signed [OUT_BITWIDTH-1:0] y,
    output logic                           y_valid,
    input  logic                           y_ready,
    output logic [5:0]                     y_index,
    output logic                           block_done,
    output logic                           sat_flag
);

    localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(TERMS - 1);
    localparam logic signed [ACC_BITWIDTH:0] OUT_MAX =
        (ACC_BITWIDTH + 1)'((2 ** (OUT_BITWIDTH - 1)) - 1);
    localparam logic signed [ACC_BITWIDTH:0] OUT_MIN = -OUT_MAX - 1;

    typedef enum logic [1:0] {ACCUM, ROUND, HOLD} state_t;

    state_t                          state;
    logic [CNT_W-1:0]                term_cnt;
    logic signed [ACC_BITWIDTH-1:0]  acc;
    logic                            pass_q;
    logic signed [ACC_BITWIDTH-1:0]  p_ext;
    logic signed [ACC_BITWIDTH:0]    rounded;

    // One extra bit so adding the rounding bias can never wrap.
    function automatic logic signed [ACC_BITWIDTH:0] round_shift(
        input logic signed [ACC_BITWIDTH-1:0] a,
        input logic                           col
    );
        logic signed [ACC_BITWIDTH:0] wide;
        logic signed [ACC_BITWIDTH:0] bias;
        int s;
        s    = col ? SHIFT_COL : SHIFT_ROW;
        bias = (ACC_BITWIDTH + 1)'(1) << (s - 1);
        wide = {a[ACC_BITWIDTH-1], a};
        return (wide + bias) >>> s;
    endfunction

    function automatic logic is_clipped(input logic signed [ACC_BITWIDTH:0] r);
        return (r > OUT_MAX) || (r < OUT_MIN);
    endfunction

    function automatic logic signed [OUT_BITWIDTH-1:0] saturate(
        input logic signed [ACC_BITWIDTH:0] r
    );
        if (r > OUT_MAX)
            return OUT_MAX[OUT_BITWIDTH-1:0];
        else if (r < OUT_MIN)
            return OUT_MIN[OUT_BITWIDTH-1:0];
        else
            return r[OUT_BITWIDTH-1:0];
    endfunction

    assign p_ext   = {{(ACC_BITWIDTH - P_BITWIDTH){p[P_BITWIDTH-1]}}, p};
    assign rounded = round_shift(acc, pass_q);
    assign p_ready = (state == ACCUM) && !flush;

    always_ff @(posedge clk) begin
        if (rstP) begin
            state      <= ACCUM;
            term_cnt   <= '0;
            acc        <= '0;
            pass_q     <= 1'b0;
            y          <= '0;
            y_valid    <= 1'b0;
            y_index    <= '0;
            block_done <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            block_done <= 1'b0;
            // flush wins over every state, including a same-cycle y handshake.
            if (flush) begin
                state    <= ACCUM;
                term_cnt <= '0;
                y_valid  <= 1'b0;
            end else begin
                case (state)
                    ACCUM: begin
                        if (p_valid) begin
                            if (term_cnt == '0) begin
                                acc    <= p_ext;
                                pass_q <= pass;
                            end else begin
                                acc <= acc + p_ext;
                            end
                            if (term_cnt == LAST_TERM) begin
                                term_cnt <= '0;
                                state    <= ROUND;
                            end else begin
                                term_cnt <= CNT_W'(term_cnt + 1'b1);
                            end
                        end
                    end
                    ROUND: begin
                        y       <= saturate(rounded);
                        y_valid <= 1'b1;
                        if (is_clipped(rounded))
                            sat_flag <= 1'b1;
                        state <= HOLD;
                    end
                    HOLD: begin
                        if (y_ready) begin
                            y_valid <= 1'b0;
                            y_index <= 6'(y_index + 1'b1);
                            if (y_index == 6'd63)
                                block_done <= 1'b1;
                            state <= ACCUM;
                        end
                    end
                    default: state <= ACCUM;
                endcase
            end
        end
    end

endmodule
